encoder_4x2_rr: RTL and testbench
=================================

ENCODER_4X2_RR -- requirements
Module: encoder_4x2_rr

Interface
REQ-001 The block SHALL have parameter PTR_INIT, default 2'd0, giving the round-robin pointer value loaded at reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 enabled  input  1  capture/selection enable; high = new requests are accepted and new codes are issued.
REQ-005 inputs  input  4  request lines, one bit per source; any number of bits may be high at once.
REQ-006 outputs  output  2  encoded index of the granted source; registered.
REQ-007 valid  output  1  high when outputs holds a code not yet taken by the consumer; registered.
REQ-008 ready  input  1  consumer accepts the code in any cycle where valid and ready are both high (handshake).
REQ-009 pending  output  4  sticky request register, exposed for status.

Function
REQ-010 When enabled=1, each edge SHALL set pending[i] for every inputs[i]=1 (pending <= pending | inputs); when enabled=0, inputs SHALL be ignored.
REQ-011 FSM states SHALL be IDLE (valid=0) and HOLD (valid=1); there are no other states.
REQ-012 IDLE -> HOLD when enabled=1 and the pending value present at the start of the cycle is nonzero; outputs SHALL be loaded with the selected index in the same edge, so valid rises one cycle after a pending bit is visible.
REQ-013 Selection SHALL be round-robin: the first set pending bit searched upward from ptr, modulo 4 (ptr, ptr+1, ptr+2, ptr+3).
REQ-014 In HOLD, outputs and valid SHALL stay stable until the handshake, regardless of inputs, enabled or further pending changes.
REQ-015 On the handshake: clear pending[outputs]; set ptr <= outputs+1, wrapping 3 -> 0; return to IDLE. This gives one idle bubble cycle per grant.
REQ-016 Simultaneous handshake and new request on the same bit with enabled=1: the set SHALL win, so the bit stays pending.
REQ-017 enabled=0 while in HOLD: the current code SHALL still complete its handshake; no new code is issued until enabled=1.
REQ-018 pending=0 in IDLE: stay in IDLE with valid=0, and outputs holds its last value.
REQ-019 ptr SHALL change only on a handshake.

Reset
REQ-020 When reset=1 at an edge: state <= IDLE, valid <= 0, outputs <= 2'd0, pending <= 4'b0000, ptr <= PTR_INIT; reset SHALL override every other input.
REQ-021 Reset mid-HOLD SHALL drop the in-flight code without a handshake; valid is low in the cycle after the reset edge.
REQ-022 Requests present during the reset edge SHALL NOT be captured.

Structure
REQ-023 A shared package SHALL hold the state encoding (IDLE=1'b0, HOLD=1'b1) and the constants NUM_SRC=4 and IDX_W=2.
REQ-024 The round-robin search SHALL be a combinational sub-module rr_pick_4 with inputs req[3:0] and ptr[1:0] and outputs idx[1:0] and any.
REQ-025 All outputs SHALL be driven directly from flops.

Verification
REQ-026 Reset, then enabled=1, inputs=4'b0100 for 1 cycle, ready=1 -> pending=4'b0100, then valid=1 with outputs=2'd2 one cycle later; after the handshake, pending=0 and valid=0.
REQ-027 inputs=4'b1111 pulsed once, ready=1 held, PTR_INIT=0 -> codes 0,1,2,3 in order, each valid for 1 cycle separated by 1 bubble cycle; ptr wraps to 0.
REQ-028 HOLD with outputs=2'd1 and ready=0 for 5 cycles while inputs toggle -> outputs and valid stay unchanged; on ready=1, ptr=2.
REQ-029 Handshake on index 3 with inputs=4'b1000 in the same cycle -> pending[3] stays 1 and the next code is 3 (after other pending sources, per REQ-013).
REQ-030 enabled=0 with inputs=4'b0011 -> pending stays 0; enabled=0 during HOLD -> the handshake still completes, then the FSM stays in IDLE.
REQ-031 reset=1 during HOLD with pending=4'b0110 -> the next cycle shows valid=0, pending=0, outputs=0, and ptr=PTR_INIT.

Source files
------------

// File: rtl/encoder_4x2_rr_pkg.sv
// encoder_4x2_rr_pkg
//   Shared definitions for the round-robin 4:2 encoder slice: source count,
//   index width, FSM state encoding and small typed helpers used by the
//   top level and the rr_pick_4 search block.
package encoder_4x2_rr_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned IDX_W   = 2;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [NUM_SRC-1:0] req_t;

  // IDLE: no code offered (valid=0). HOLD: code offered until handshake.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Next index with natural wrap 3 -> 0.
  function automatic idx_t idx_inc(input idx_t i);
    return i + idx_t'(1);
  endfunction

  // One-hot mask for a given index.
  function automatic req_t idx_mask(input idx_t i);
    return req_t'(1) << i;
  endfunction

endpackage

// File: rtl/encoder_4x2_rr_pick.sv
// rr_pick_4
//   Combinational round-robin search over four request bits.
//   Ports:
//     req  in   4  request vector
//     ptr  in   2  index searched first; search proceeds ptr, ptr+1, ... mod 4
//     idx  out  2  first set request found (0 when none)
//     any  out  1  high when at least one request bit is set
module rr_pick_4
  import encoder_4x2_rr_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  idx_t cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      // Index arithmetic wraps naturally at IDX_W bits.
      cand = ptr + idx_t'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_4x2_rr.sv
// encoder_4x2_rr
//   Sticky-request round-robin encoder with a valid/ready output handshake.
//   Requests are OR-ed into a pending register while enabled; in IDLE the
//   first pending source at or after the round-robin pointer is granted and
//   its index held on outputs until the consumer takes it.
//   Ports:
//     clk      in   1  clock, rising edge
//     reset    in   1  synchronous, active-high
//     enabled  in   1  accept new requests and issue new codes
//     inputs   in   4  request lines
//     outputs  out  2  granted index (registered)
//     valid    out  1  outputs holds an untaken code (registered)
//     ready    in   1  consumer takes the code when valid & ready
//     pending  out  4  sticky request register
module encoder_4x2_rr
  import encoder_4x2_rr_pkg::*;
#(
  parameter logic [IDX_W-1:0] PTR_INIT = 2'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enabled,
  input  logic [NUM_SRC-1:0] inputs,
  output logic [IDX_W-1:0]   outputs,
  output logic               valid,
  input  logic               ready,
  output logic [NUM_SRC-1:0] pending
);

  state_e state_q, state_d;
  idx_t   outputs_q, outputs_d;
  logic   valid_q, valid_d;
  req_t   pending_q, pending_d;
  idx_t   ptr_q, ptr_d;

  idx_t   pick_idx;
  logic   pick_any;
  logic   handshake;

  // Search uses the pending value present at the start of the cycle.
  rr_pick_4 u_pick (
    .req (pending_q),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign handshake = (state_q == HOLD) && ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      outputs_q <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
      ptr_q     <= PTR_INIT;
    end else begin
      state_q   <= state_d;
      outputs_q <= outputs_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enabled && pick_any) state_d = HOLD;
      HOLD: if (handshake)           state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Registered-output next values
  always_comb begin
    outputs_d = outputs_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;

    // Clear the taken source before merging new requests so a simultaneous
    // request on the same bit keeps it pending.
    if (handshake) begin
      pending_d = pending_d & ~idx_mask(outputs_q);
      ptr_d     = idx_inc(outputs_q);
    end
    if (enabled) begin
      pending_d = pending_d | inputs;
    end

    if (state_q == IDLE && enabled && pick_any) begin
      outputs_d = pick_idx;
    end

    valid_d = (state_d == HOLD);
  end

  assign outputs = outputs_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_encoder_4x2_rr.sv
module tb_encoder_4x2_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic       enabled;
  logic [3:0] inputs;
  logic [1:0] outputs;
  logic       valid;
  logic       ready;
  logic [3:0] pending;

  int n_asrt = 0;
  int n_fail = 0;

  logic [1:0] sb[$];

  encoder_4x2_rr #(.PTR_INIT(2'd0)) dut (
    .clk     (clk),
    .reset   (reset),
    .enabled (enabled),
    .inputs  (inputs),
    .outputs (outputs),
    .valid   (valid),
    .ready   (ready),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every code taken by the consumer must match the next
  // expected grant pushed by the stimulus.
  always @(negedge clk) begin
    if (!reset && valid && ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_code", 32'(outputs), 32'hFFFF);
      end else begin
        chk("sb_code", 32'(outputs), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; enabled = 1'b0; inputs = 4'b0; ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_valid",   32'(valid),      32'd0);
    chk("rst_outputs", 32'(outputs),    32'd0);
    chk("rst_pending", 32'(pending),    32'd0);
    chk("rst_ptr",     32'(dut.ptr_q),  32'd0);

    // Single request on source 2
    enabled = 1'b1; inputs = 4'b0100; ready = 1'b1; sb.push_back(2'd2);
    cyc();
    inputs = 4'b0;
    chk("single_pending", 32'(pending), 32'b0100);
    chk("single_valid0",  32'(valid),   32'd0);
    cyc();
    chk("single_valid1",  32'(valid),   32'd1);
    chk("single_code",    32'(outputs), 32'd2);
    cyc();
    chk("single_pend_clr", 32'(pending), 32'd0);
    chk("single_valid_lo", 32'(valid),   32'd0);
    chk("single_ptr",      32'(dut.ptr_q), 32'd3);
    chk("idle_out_hold",   32'(outputs), 32'd2);

    // All four sources at once, starting from ptr 0
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rst2_ptr", 32'(dut.ptr_q), 32'd0);
    inputs = 4'b1111;
    for (int i = 0; i < 4; i++) sb.push_back(2'(i));
    cyc();
    inputs = 4'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr4_valid", 32'(valid), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("rr4_ptr_wrap", 32'(dut.ptr_q), 32'd0);
    chk("rr4_pending",  32'(pending),   32'd0);

    // Hold stability with ready low and inputs toggling
    ready = 1'b0; inputs = 4'b0010; sb.push_back(2'd1);
    cyc();
    inputs = 4'b0;
    cyc();
    chk("hold_valid",  32'(valid),   32'd1);
    chk("hold_code",   32'(outputs), 32'd1);
    for (int i = 0; i < 5; i++) begin
      inputs = (i % 2 == 1) ? 4'b0101 : 4'b1000;
      cyc();
      chk("hold_valid_stable", 32'(valid),   32'd1);
      chk("hold_code_stable",  32'(outputs), 32'd1);
    end
    // Pending now 1111; after taking 1 the order from ptr 2 is 2,3,0
    sb.push_back(2'd2); sb.push_back(2'd3); sb.push_back(2'd0);
    inputs = 4'b0; ready = 1'b1;
    cyc();
    chk("hold_ptr",     32'(dut.ptr_q), 32'd2);
    chk("hold_pending", 32'(pending),   32'b1101);
    chk("hold_valid_lo", 32'(valid),    32'd0);
    for (int i = 0; i < 6; i++) cyc();
    chk("hold_drain_pending", 32'(pending),   32'd0);
    chk("hold_drain_ptr",     32'(dut.ptr_q), 32'd1);

    // Handshake on 3 with a fresh request on 3 in the same cycle
    ready = 1'b0; inputs = 4'b1001; sb.push_back(2'd3);
    cyc();
    inputs = 4'b0;
    cyc();
    chk("set_win_code", 32'(outputs), 32'd3);
    ready = 1'b1; inputs = 4'b1000;
    sb.push_back(2'd0); sb.push_back(2'd3);
    cyc();
    inputs = 4'b0;
    chk("set_win_pending", 32'(pending),   32'b1001);
    chk("set_win_ptr",     32'(dut.ptr_q), 32'd0);
    for (int i = 0; i < 4; i++) cyc();
    chk("set_win_drain", 32'(pending),   32'd0);
    chk("set_win_ptr2",  32'(dut.ptr_q), 32'd0);
    chk("set_win_valid", 32'(valid),     32'd0);

    // Requests ignored while disabled
    enabled = 1'b0; inputs = 4'b0011;
    cyc(); cyc();
    chk("dis_pending", 32'(pending), 32'd0);
    chk("dis_valid",   32'(valid),   32'd0);

    // Disable during HOLD: code completes, nothing new issued
    enabled = 1'b1; ready = 1'b0; inputs = 4'b0110; sb.push_back(2'd1);
    cyc();
    inputs = 4'b0;
    cyc();
    enabled = 1'b0; inputs = 4'b1000;
    cyc();
    chk("dis_hold_valid",   32'(valid),   32'd1);
    chk("dis_hold_code",    32'(outputs), 32'd1);
    chk("dis_hold_pending", 32'(pending), 32'b0110);
    ready = 1'b1;
    cyc();
    chk("dis_hs_ptr", 32'(dut.ptr_q), 32'd2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("dis_idle_valid",   32'(valid),   32'd0);
      chk("dis_idle_pending", 32'(pending), 32'b0100);
    end

    // Reset during HOLD drops the code; requests at the reset edge are lost
    enabled = 1'b1; ready = 1'b0; inputs = 4'b0010;
    cyc();
    inputs = 4'b0;
    chk("pre_rst_valid",   32'(valid),   32'd1);
    chk("pre_rst_code",    32'(outputs), 32'd2);
    chk("pre_rst_pending", 32'(pending), 32'b0110);
    reset = 1'b1; inputs = 4'b1111; ready = 1'b1;
    cyc();
    chk("mid_rst_valid",   32'(valid),     32'd0);
    chk("mid_rst_pending", 32'(pending),   32'd0);
    chk("mid_rst_outputs", 32'(outputs),   32'd0);
    chk("mid_rst_ptr",     32'(dut.ptr_q), 32'd0);
    reset = 1'b0; inputs = 4'b0; ready = 1'b0;
    cyc();
    chk("post_rst_pending", 32'(pending), 32'd0);
    chk("post_rst_valid",   32'(valid),   32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
